// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with double-buffered digit data, guard blanking and leading-zero blanking.
// Latency: pins follow (slot counter, digit index, active set) by one CLK; a LOAD_IN capture shows from the next frame swap.
// Backpressure: none; LOAD_IN is always accepted and a later load overwrites a capture that has not been swapped in yet.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD_CYCLES  = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] BIN_IN,
    input  logic [NUM_DIGITS-1:0]   DOT_IN,
    input  logic [NUM_DIGITS-1:0]   EN_IN,
    input  logic                    LOAD_IN,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT,
    output logic                    SCAN_TICK_OUT
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dot;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dot;
    logic [NUM_DIGITS-1:0]   act_en;

    logic [NUM_DIGITS-1:0]   suppress;
    logic                    upper_zero;
    logic                    in_guard;
    logic                    blank;
    logic [3:0]              cur_nib;

    // Hex nibble to active-low segment pattern, bit order g..a.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_code = 7'h40;
            4'h1:    seg_code = 7'h79;
            4'h2:    seg_code = 7'h24;
            4'h3:    seg_code = 7'h30;
            4'h4:    seg_code = 7'h19;
            4'h5:    seg_code = 7'h12;
            4'h6:    seg_code = 7'h02;
            4'h7:    seg_code = 7'h78;
            4'h8:    seg_code = 7'h00;
            4'h9:    seg_code = 7'h18;
            4'hA:    seg_code = 7'h08;
            4'hB:    seg_code = 7'h03;
            4'hC:    seg_code = 7'h46;
            4'hD:    seg_code = 7'h21;
            4'hE:    seg_code = 7'h06;
            default: seg_code = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A zero guard length removes the comparison entirely instead of comparing against zero.
    if (GUARD_CYCLES > 0) begin : g_guard
        assign in_guard = (cnt < CNT_W'(GUARD_CYCLES));
    end else begin : g_no_guard
        assign in_guard = 1'b0;
    end

    // Prescaler and digit index: one slot per REFRESH_DIV cycles, index wraps after the last digit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending; pending moves to active only when a frame completes.
    // A load on the swap cycle lands in pending after the swap has taken the older capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_val   <= '0;
            pend_dot   <= '0;
            pend_en    <= '1;
            pend_valid <= 1'b0;
            act_val    <= '0;
            act_dot    <= '0;
            act_en     <= '1;
        end else begin
            if (frame_end && pend_valid) begin
                act_val <= pend_val;
                act_dot <= pend_dot;
                act_en  <= pend_en;
            end
            if (LOAD_IN) begin
                pend_val   <= BIN_IN;
                pend_dot   <= DOT_IN;
                pend_en    <= EN_IN;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero map: a digit is blanked while it and every digit above it are zero with no dot.
    always_comb begin
        suppress   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (act_val[4*k +: 4] == 4'h0) && !act_dot[k];
            suppress[k] = upper_zero && BLANK_LEADING;
        end
    end

    assign cur_nib = act_val[{idx, 2'b00} +: 4];
    assign blank   = in_guard || !act_en[idx] || suppress[idx];

    // Registered pin stage so anodes, segments and tick never glitch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= 8'hFF;
            SCAN_TICK_OUT  <= 1'b0;
        end else begin
            SCAN_TICK_OUT <= slot_end;
            if (blank) begin
                SEG_SELECT_OUT <= '1;
                HEX_OUT        <= 8'hFF;
            end else begin
                SEG_SELECT_OUT <= ~(NUM_DIGITS'(1) << idx);
                HEX_OUT        <= {~act_dot[idx], seg_code(cur_nib)};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int FRAME = N * DIV;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] BIN_IN = 16'h0;
    logic [3:0]  DOT_IN = 4'h0;
    logic [3:0]  EN_IN = 4'hF;
    logic        LOAD_IN = 1'b0;

    // Instance 0: guard 2, blanking on; 1: blanking off; 2: guard 0; 3: guard 7.
    logic [3:0]  sel_o [4];
    logic [7:0]  hex_o [4];
    logic        tick_o [4];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(2), .BLANK_LEADING(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .BIN_IN(BIN_IN), .DOT_IN(DOT_IN), .EN_IN(EN_IN), .LOAD_IN(LOAD_IN),
        .SEG_SELECT_OUT(sel_o[0]), .HEX_OUT(hex_o[0]), .SCAN_TICK_OUT(tick_o[0]));
    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(2), .BLANK_LEADING(1'b0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .BIN_IN(BIN_IN), .DOT_IN(DOT_IN), .EN_IN(EN_IN), .LOAD_IN(LOAD_IN),
        .SEG_SELECT_OUT(sel_o[1]), .HEX_OUT(hex_o[1]), .SCAN_TICK_OUT(tick_o[1]));
    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(0), .BLANK_LEADING(1'b1)) dut_g0 (
        .CLK(CLK), .RESET(RESET), .BIN_IN(BIN_IN), .DOT_IN(DOT_IN), .EN_IN(EN_IN), .LOAD_IN(LOAD_IN),
        .SEG_SELECT_OUT(sel_o[2]), .HEX_OUT(hex_o[2]), .SCAN_TICK_OUT(tick_o[2]));
    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(7), .BLANK_LEADING(1'b1)) dut_g7 (
        .CLK(CLK), .RESET(RESET), .BIN_IN(BIN_IN), .DOT_IN(DOT_IN), .EN_IN(EN_IN), .LOAD_IN(LOAD_IN),
        .SEG_SELECT_OUT(sel_o[3]), .HEX_OUT(hex_o[3]), .SCAN_TICK_OUT(tick_o[3]));

    // ---------------- reference model ----------------
    logic [6:0]  seg_tab [16];
    int          t = 0;              // clock edges since reset; slot/digit/frame follow by division
    logic [15:0] m_act_v = 16'h0, m_pen_v = 16'h0;
    logic [3:0]  m_act_d = 4'h0, m_pen_d = 4'h0, m_act_e = 4'hF, m_pen_e = 4'hF;
    logic        m_pv = 1'b0;
    logic [3:0]  exp_sel [4];
    logic [7:0]  exp_hex [4];
    logic        exp_tick = 1'b0;

    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h18; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        for (int i = 0; i < 4; i++) begin
            exp_sel[i] = 4'hF;
            exp_hex[i] = 8'hFF;
        end
    end

    function automatic int guard_of(input int i);
        return (i == 2) ? 0 : (i == 3) ? 7 : 2;
    endfunction

    // Pin values for instance i while showing digit idx at slot position cnt.
    function automatic logic [11:0] expect_out(input int i, input int cnt, input int idx);
        int top;
        top = 0;
        for (int j = 0; j < N; j++)
            if (m_act_v[4*j +: 4] != 4'h0 || m_act_d[j]) top = j;
        if (cnt < guard_of(i) || !m_act_e[idx] || (i != 1 && idx > top))
            return {4'hF, 8'hFF};
        return {~(4'b0001 << idx), ~m_act_d[idx], seg_tab[m_act_v[4*idx +: 4]]};
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            t <= 0;
            m_act_v <= 16'h0; m_act_d <= 4'h0; m_act_e <= 4'hF;
            m_pen_v <= 16'h0; m_pen_d <= 4'h0; m_pen_e <= 4'hF;
            m_pv <= 1'b0;
            exp_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                exp_sel[i] <= 4'hF;
                exp_hex[i] <= 8'hFF;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                {exp_sel[i], exp_hex[i]} <= expect_out(i, t % DIV, (t / DIV) % N);
            exp_tick <= (t % DIV == DIV - 1);
            if (t % FRAME == FRAME - 1 && m_pv) begin
                m_act_v <= m_pen_v; m_act_d <= m_pen_d; m_act_e <= m_pen_e;
            end
            if (LOAD_IN) begin
                m_pen_v <= BIN_IN; m_pen_d <= DOT_IN; m_pen_e <= EN_IN;
                m_pv <= 1'b1;
            end else if (t % FRAME == FRAME - 1) begin
                m_pv <= 1'b0;
            end
            t <= t + 1;
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sel_o[i] !== exp_sel[i] || hex_o[i] !== exp_hex[i] || tick_o[i] !== exp_tick) begin
                    errors++;
                    $display("FAIL model inst%0d t=%0d: sel=%b hex=%h tick=%b, required sel=%b hex=%h tick=%b",
                             i, t, sel_o[i], hex_o[i], tick_o[i], exp_sel[i], exp_hex[i], exp_tick);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a negedge; leaves LOAD_IN high for exactly one rising edge.
    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        BIN_IN = v; DOT_IN = d; EN_IN = e; LOAD_IN = 1'b1;
        @(negedge CLK);
        LOAD_IN = 1'b0;
    endtask

    task automatic align(input int phase);
        int w;
        w = 0;
        while (t % FRAME != phase && w < 2 * FRAME) begin
            @(negedge CLK);
            w++;
        end
        if (t % FRAME != phase) check("align", t % FRAME, phase);
    endtask

    // Observe one frame: per-digit shown value (FF if never lit), lit cycles, ticks, multi-low anodes.
    task automatic collect(input int inst, output logic [31:0] hexes, output int vis, output int ticks,
                           output int multi);
        hexes = 32'hFFFF_FFFF; vis = 0; ticks = 0; multi = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge CLK);
            if (tick_o[inst]) ticks++;
            if (sel_o[inst] != 4'hF) begin
                vis++;
                if ($countones(~sel_o[inst]) > 1) multi++;
                for (int k = 0; k < N; k++)
                    if (!sel_o[inst][k]) hexes[8*k +: 8] = hex_o[inst];
            end
        end
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [3:0]  dot;
        logic [3:0]  en;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0}; FF = never lit
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] hx;
    int          vis, ticks, multi, bad;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'hF,    32'hF9A4B099};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF,    32'hFFFF92C0};
        vecs[2] = '{16'h0050, 4'b1000, 4'hF,    32'h40C092C0};
        vecs[3] = '{16'h8888, 4'b0001, 4'b0101, 32'hFF80FF00};
        vecs[4] = '{16'h0000, 4'b0000, 4'hF,    32'hFFFFFFC0};
        vecs[5] = '{16'hABCD, 4'b0000, 4'hF,    32'h8883C6A1};
        vecs[6] = '{16'h0EF0, 4'b0000, 4'hF,    32'hFF868EC0};
        vecs[7] = '{16'h0007, 4'b0010, 4'hF,    32'hFFFF40F8};
        vecs[8] = '{16'h0600, 4'b0000, 4'b1011, 32'hFFFFC0C0};

        repeat (2) @(negedge CLK);
        check("reset sel", sel_o[0], 4'hF);
        check("reset hex", hex_o[0], 8'hFF);
        check("reset tick", tick_o[0], 1'b0);
        RESET = 1'b0;

        // Table: load, let the set reach the active buffer, then observe a whole frame.
        for (int v = 0; v < 9; v++) begin
            load(vecs[v].bin, vecs[v].dot, vecs[v].en);
            repeat (2 * FRAME + 2) @(negedge CLK);
            collect(0, hx, vis, ticks, multi);
            for (int k = 0; k < N; k++)
                check($sformatf("vec%0d digit%0d", v, k), hx[8*k +: 8], vecs[v].exp[8*k +: 8]);
            check($sformatf("vec%0d one anode", v), multi, 0);
        end

        // Guard lengths and tick rate.
        load(16'h1234, 4'h0, 4'hF);
        repeat (2 * FRAME + 2) @(negedge CLK);
        collect(0, hx, vis, ticks, multi);
        check("guard2 lit cycles", vis, 24);
        check("ticks per frame", ticks, 4);
        collect(2, hx, vis, ticks, multi);
        check("guard0 lit cycles", vis, 32);
        collect(3, hx, vis, ticks, multi);
        check("guard7 lit cycles", vis, 4);
        check("guard7 digit0", hx[7:0], 8'h99);

        // Leading-zero blanking off shows the zeros.
        load(16'h0050, 4'h0, 4'hF);
        repeat (2 * FRAME + 2) @(negedge CLK);
        collect(1, hx, vis, ticks, multi);
        check("no-blank 0050", hx, 32'hC0C092C0);

        // Mid-frame load does not disturb the frame in progress.
        load(16'hAAAA, 4'h0, 4'hF);
        repeat (2 * FRAME + 2) @(negedge CLK);
        align(8);
        load(16'h5555, 4'h0, 4'hF);
        vis = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (sel_o[0] != 4'hF) begin
                vis++;
                if (hex_o[0] != 8'h88) bad++;
            end
        end
        check("tear-free lit", vis > 0, 1'b1);
        check("tear-free old value", bad, 0);
        repeat (FRAME + 8) @(negedge CLK);
        collect(0, hx, vis, ticks, multi);
        check("new frame 5555", hx, 32'h92929292);

        // Two loads inside one frame: the first is overwritten and never shown.
        align(2);
        load(16'hAAAA, 4'h0, 4'hF);
        repeat (6) @(negedge CLK);
        load(16'h5555, 4'h0, 4'hF);
        bad = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge CLK);
            if (sel_o[0] != 4'hF && hex_o[0] == 8'h88) bad++;
        end
        check("overwritten never shown", bad, 0);

        // Load on the swap edge: the older capture goes live, the new one a frame later.
        align(5);
        load(16'h1111, 4'h0, 4'hF);
        align(FRAME - 1);
        load(16'h2222, 4'h0, 4'hF);
        collect(0, hx, vis, ticks, multi);
        check("swap-cycle frame1", hx, 32'hF9F9F9F9);
        collect(0, hx, vis, ticks, multi);
        check("swap-cycle frame2", hx, 32'hA4A4A4A4);

        // Asynchronous reset while a digit is lit and a load is in flight.
        align(4);
        check("pre-reset lit", sel_o[0] != 4'hF, 1'b1);
        BIN_IN = 16'h9999; DOT_IN = 4'hF; EN_IN = 4'hF; LOAD_IN = 1'b1;
        #2 RESET = 1'b1;
        #1;
        check("async reset sel", sel_o[0], 4'hF);
        check("async reset hex", hex_o[0], 8'hFF);
        check("async reset tick", tick_o[0], 1'b0);
        @(negedge CLK);
        LOAD_IN = 1'b0;
        RESET = 1'b0;
        repeat (2 * FRAME + 2) @(negedge CLK);
        collect(0, hx, vis, ticks, multi);
        check("reset drops pending", hx, 32'hFFFFFFC0);

        // Random loads against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       BIN_IN = 16'($urandom);
                    1:       BIN_IN = 16'($urandom) & 16'h0FFF;
                    2:       BIN_IN = 16'($urandom) & 16'h00FF;
                    3:       BIN_IN = 16'($urandom) & 16'h000F;
                    default: BIN_IN = 16'h0000;
                endcase
                DOT_IN  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                EN_IN   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                LOAD_IN = 1'b1;
            end else begin
                LOAD_IN = 1'b0;
            end
            @(negedge CLK);
        end
        LOAD_IN = 1'b0;
        repeat (4) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
